// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - per-pixel, per-kernel sequencer for a convolution frame
module conv_layer_scheduler #(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int NUM_LAYERS  = 5,
  parameter int NUM_KERNELS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       patch_req,
  output logic [7:0] patch_x,
  output logic [7:0] patch_y,
  input  logic       patch_ack,
  output logic       eng_start,
  output logic [2:0] eng_layer,
  output logic [5:0] eng_kernel,
  input  logic       eng_done,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_x,
  output logic [7:0] wr_y,
  output logic [2:0] wr_layer,
  output logic [5:0] wr_kernel
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    RUN     = 3'd2,
    WAIT    = 3'd3,
    WRITE   = 3'd4,
    ADVANCE = 3'd5
  } state_t;

  localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);
  localparam logic [2:0] L_LAST = 3'(NUM_LAYERS - 1);
  localparam logic [5:0] K_LAST = 6'(NUM_KERNELS - 1);

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] layer_q, layer_d;
  logic [5:0] kernel_q, kernel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       patch_req_q, patch_req_d;
  logic       eng_start_q, eng_start_d;
  logic       wr_valid_q, wr_valid_d;

  // Next state, loop counters and the registered strobes that follow the next state.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    layer_d  = layer_q;
    kernel_d = kernel_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          x_d      = 8'd0;
          y_d      = 8'd0;
          layer_d  = 3'd0;
          kernel_d = 6'd0;
        end
      end
      FETCH: begin
        if (patch_ack) state_d = RUN;
      end
      RUN: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) state_d = WRITE;
      end
      WRITE: begin
        if (wr_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (kernel_q != K_LAST) begin
          // Same pixel, next kernel: the loaded patch is reused.
          kernel_d = kernel_q + 6'd1;
          state_d  = RUN;
        end else begin
          kernel_d = 6'd0;
          state_d  = FETCH;
          if (x_q != X_LAST) begin
            x_d = x_q + 8'd1;
          end else begin
            x_d = 8'd0;
            if (y_q != Y_LAST) begin
              y_d = y_q + 8'd1;
            end else begin
              y_d = 8'd0;
              if (layer_q != L_LAST) begin
                layer_d = layer_q + 3'd1;
              end else begin
                layer_d = 3'd0;
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort outranks every other input, including a start seen in IDLE.
    if (abort) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      x_d      = 8'd0;
      y_d      = 8'd0;
      layer_d  = 3'd0;
      kernel_d = 6'd0;
    end

    busy_d      = (state_d != IDLE);
    patch_req_d = (state_d == FETCH);
    eng_start_d = (state_d == RUN);
    wr_valid_d  = (state_d == WRITE);
  end

  // State, counters and output strobes; reset drops everything to an idle, zeroed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      layer_q     <= 3'd0;
      kernel_q    <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      patch_req_q <= 1'b0;
      eng_start_q <= 1'b0;
      wr_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      layer_q     <= layer_d;
      kernel_q    <= kernel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      patch_req_q <= patch_req_d;
      eng_start_q <= eng_start_d;
      wr_valid_q  <= wr_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign patch_req  = patch_req_q;
  assign patch_x    = x_q;
  assign patch_y    = y_q;
  assign eng_start  = eng_start_q;
  assign eng_layer  = layer_q;
  assign eng_kernel = kernel_q;
  assign wr_valid   = wr_valid_q;
  assign wr_x       = x_q;
  assign wr_y       = y_q;
  assign wr_layer   = layer_q;
  assign wr_kernel  = kernel_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - directed vector bench for conv_layer_scheduler
module tb_conv_layer_scheduler;

  localparam int W = 2;
  localparam int H = 2;
  localparam int L = 2;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, patch_ack, eng_done, wr_ready;
  logic       busy, done, patch_req, eng_start, wr_valid;
  logic [7:0] patch_x, patch_y, wr_x, wr_y;
  logic [2:0] eng_layer, wr_layer;
  logic [5:0] eng_kernel, wr_kernel;

  conv_layer_scheduler #(
    .IMG_W(W), .IMG_H(H), .NUM_LAYERS(L), .NUM_KERNELS(K)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .patch_req(patch_req), .patch_x(patch_x), .patch_y(patch_y), .patch_ack(patch_ack),
    .eng_start(eng_start), .eng_layer(eng_layer), .eng_kernel(eng_kernel), .eng_done(eng_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_layer(wr_layer), .wr_kernel(wr_kernel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tie;
    int ack_d;
    int done_d;
    int rdy_d;
    int rdy_first;
    int exp_fetch;
    int exp_wr;
    int exp_lat;
  } vec_t;

  vec_t vecs[6];

  int n_cmp, n_fail, cyc;
  bit m_tie, force_done;
  int m_ack_d, m_done_d, m_rdy_d, m_rdy_first;
  int fcnt, dcnt, wcnt;
  bit dpend;
  int wr_n, fetch_n, done_cnt, done_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ex_l(input int i); return i / (H * W * K); endfunction
  function automatic int ex_y(input int i); return (i / (W * K)) % H; endfunction
  function automatic int ex_x(input int i); return (i / K) % W; endfunction
  function automatic int ex_k(input int i); return i % K; endfunction

  task automatic set_mode(input bit tie, input int a, input int d, input int r, input int rf);
    m_tie = tie; m_ack_d = a; m_done_d = d; m_rdy_d = r; m_rdy_first = rf;
  endtask

  task automatic clr_mon();
    fcnt = 0; dcnt = 0; wcnt = 0; dpend = 0; wr_n = 0; fetch_n = 0;
    patch_ack = 0; eng_done = 0; wr_ready = 0; force_done = 0;
  endtask

  // One clock: drive responder inputs at the falling edge, then check what is visible.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m_tie) begin
      patch_ack = 1; eng_done = 1; wr_ready = 1;
    end else begin
      if (patch_req) begin patch_ack = (fcnt == m_ack_d); fcnt++; end
      else begin patch_ack = 0; fcnt = 0; end
      if (eng_start) begin dpend = 1; dcnt = 0; eng_done = 0; end
      else if (dpend) begin
        if (dcnt == m_done_d) begin eng_done = 1; dpend = 0; end
        else begin eng_done = 0; dcnt++; end
      end else eng_done = 0;
      if (wr_valid) begin wr_ready = (wcnt == ((wr_n == 0) ? m_rdy_first : m_rdy_d)); wcnt++; end
      else begin wr_ready = 0; wcnt = 0; end
    end
    if (force_done) eng_done = 1;

    if (patch_req && patch_ack) begin
      chk("patch_x", int'(patch_x), fetch_n % W);
      chk("patch_y", int'(patch_y), (fetch_n / W) % H);
      fetch_n++;
    end
    if (eng_start) begin
      chk("eng_layer", int'(eng_layer), ex_l(wr_n));
      chk("eng_kernel", int'(eng_kernel), ex_k(wr_n));
    end
    if (wr_valid) begin
      chk("wr_layer", int'(wr_layer), ex_l(wr_n));
      chk("wr_y", int'(wr_y), ex_y(wr_n));
      chk("wr_x", int'(wr_x), ex_x(wr_n));
      chk("wr_kernel", int'(wr_kernel), ex_k(wr_n));
      if (wr_ready) wr_n++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic start_frame(output int cs);
    start = 1;
    cs = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", budget);
    end
  endtask

  task automatic full_frame_checks(input string tag, input int cs, input int exp_lat);
    bit ok;
    int d0;
    d0 = done_cnt;
    wait_done(3000, ok);
    if (ok) chk({tag, "_latency"}, done_cyc - cs - 1, exp_lat);
    chk({tag, "_writes"}, wr_n, L * H * W * K);
    chk({tag, "_fetches"}, fetch_n, L * H * W);
    repeat (3) tick();
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int cs, d0;
    bit ok, found;

    n_cmp = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
    start = 0; abort = 0; rst_n = 1;
    set_mode(0, 0, 0, 0, 0);
    clr_mon();

    // inputs/expected: tie, ack_d, done_d, rdy_d, rdy_first -> fetches, writes, start-to-done cycles
    vecs[0] = '{1, 0, 0, 0, 0, 8, 24, 104};
    vecs[1] = '{0, 0, 0, 0, 0, 8, 24, 104};
    vecs[2] = '{0, 0, 0, 0, 5, 8, 24, 109};
    vecs[3] = '{0, 2, 0, 0, 0, 8, 24, 120};
    vecs[4] = '{0, 0, 1, 2, 2, 8, 24, 176};
    vecs[5] = '{0, 1, 3, 1, 4, 8, 24, 211};

    #2 rst_n = 0;
    repeat (2) tick();
    chk("rst_strobes", int'({busy, done, patch_req, eng_start, wr_valid}), 0);
    chk("rst_index", int'(|{patch_x, patch_y, wr_x, wr_y, wr_layer, wr_kernel, eng_layer, eng_kernel}), 0);
    rst_n = 1;
    tick();

    // start together with abort in IDLE stays idle
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    tick();
    chk("start_abort_idle_busy", int'(busy), 0);
    chk("start_abort_idle_req", int'(patch_req), 0);

    // eng_done while idle does nothing
    force_done = 1;
    repeat (3) tick();
    force_done = 0;
    chk("idle_eng_done_busy", int'(busy), 0);
    chk("idle_eng_done_wr", int'(wr_valid), 0);

    for (int v = 0; v < 6; v++) begin
      set_mode(vecs[v].tie, vecs[v].ack_d, vecs[v].done_d, vecs[v].rdy_d, vecs[v].rdy_first);
      clr_mon();
      d0 = done_cnt;
      start_frame(cs);
      wait_done(3000, ok);
      if (ok) chk($sformatf("v%0d_latency", v), done_cyc - cs - 1, vecs[v].exp_lat);
      chk($sformatf("v%0d_writes", v), wr_n, vecs[v].exp_wr);
      chk($sformatf("v%0d_fetches", v), fetch_n, vecs[v].exp_fetch);
      repeat (3) tick();
      chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_idle", v), int'(busy), 0);
    end

    // eng_done pulsed while a patch load is still outstanding
    set_mode(0, 4, 0, 0, 0);
    clr_mon();
    start_frame(cs);
    force_done = 1;
    tick(); tick();
    force_done = 0;
    tick();
    chk("fetch_done_req_held", int'(patch_req), 1);
    chk("fetch_done_no_run", int'(eng_start), 0);
    chk("fetch_done_no_write", int'(wr_valid), 0);
    full_frame_checks("fetch_done", cs, 136);

    // abort while waiting on the engine at layer 1, x 1
    set_mode(0, 0, 3, 0, 0);
    clr_mon();
    d0 = done_cnt;
    start_frame(cs);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (eng_start && wr_n == 15) begin found = 1; break; end
    end
    chk("abort_reached_target", int'(found), 1);
    chk("abort_target_layer", int'(eng_layer), 1);
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobes", int'({patch_req, eng_start, wr_valid, done}), 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_write", wr_n, 15);
    set_mode(0, 0, 0, 0, 0);
    clr_mon();
    start_frame(cs);
    chk("restart_req", int'(patch_req), 1);
    chk("restart_xy", int'({patch_x, patch_y}), 0);
    chk("restart_layer", int'(eng_layer), 0);
    full_frame_checks("restart", cs, 104);

    // asynchronous reset in the middle of a stalled write
    set_mode(0, 0, 0, 10, 10);
    clr_mon();
    d0 = done_cnt;
    start_frame(cs);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (wr_valid && wr_n == 5) begin found = 1; break; end
    end
    chk("rst_mid_reached", int'(found), 1);
    chk("rst_mid_pre_x", int'(wr_x), 1);
    rst_n = 0;
    #1;
    chk("rst_mid_strobes", int'({busy, done, patch_req, eng_start, wr_valid}), 0);
    chk("rst_mid_index", int'(|{patch_x, patch_y, wr_x, wr_y, wr_layer, wr_kernel, eng_layer, eng_kernel}), 0);
    tick();
    rst_n = 1;
    set_mode(0, 0, 0, 0, 0);
    clr_mon();
    repeat (4) tick();
    chk("rst_release_idle", int'(busy), 0);
    chk("rst_release_no_done", done_cnt - d0, 0);
    start_frame(cs);
    full_frame_checks("post_rst", cs, 104);

    // start re-pulsed during a frame
    set_mode(0, 0, 0, 0, 0);
    clr_mon();
    start_frame(cs);
    repeat (20) tick();
    start = 1;
    tick();
    start = 0;
    repeat (30) tick();
    start = 1;
    tick();
    start = 0;
    full_frame_checks("restart_ignored", cs, 104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_scheduler.md
CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 64, output-map width in pixels (2..255).
REQ-002 SHALL have parameter IMG_H, default 64, output-map height in pixels (2..255).
REQ-003 SHALL have parameter NUM_LAYERS, default 5, conv layers per frame (1..8).
REQ-004 SHALL have parameter NUM_KERNELS, default 64, kernels per layer (1..64).
REQ-005 SHALL have ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: start in 1, frame-start pulse; abort in 1, synchronous cancel.
REQ-007 SHALL have ports: busy out 1, frame in progress; done out 1, one-cycle end-of-frame pulse.
REQ-008 SHALL have ports: patch_req out 1, patch_x out 8, patch_y out 8, patch_ack in 1, 3x3x3 patch-load handshake.
REQ-009 SHALL have ports: eng_start out 1, eng_layer out 3, eng_kernel out 6, eng_done in 1, MAC-engine control.
REQ-010 SHALL have ports: wr_valid out 1, wr_ready in 1, wr_x out 8, wr_y out 8, wr_layer out 3, wr_kernel out 6, result-write handshake.

Function
REQ-011 SHALL implement states IDLE, FETCH, RUN, WAIT, WRITE, ADVANCE.
REQ-012 SHALL leave IDLE only on start=1, clearing layer/y/x/kernel counters to 0 and entering FETCH next cycle.
REQ-013 SHALL ignore start while busy=1.
REQ-014 SHALL hold patch_req=1 with stable patch_x=x, patch_y=y throughout FETCH; on patch_ack=1 go to RUN.
REQ-015 SHALL assert eng_start for exactly one cycle in RUN, with eng_layer=layer, eng_kernel=kernel, then go to WAIT.
REQ-016 SHALL stay in WAIT until eng_done=1, then go to WRITE; eng_done outside WAIT ignored.
REQ-017 SHALL hold wr_valid=1 with stable wr_x/wr_y/wr_layer/wr_kernel in WRITE until wr_ready=1; transfer on the cycle both are 1, then go to ADVANCE.
REQ-018 SHALL in ADVANCE step counters, kernel innermost, then x, y, layer (outermost).
REQ-019 SHALL, if kernel<NUM_KERNELS-1, increment kernel and go to RUN (no patch refetch).
REQ-020 SHALL otherwise wrap kernel to 0, advance x (wrap at IMG_W-1 into y, y wrap at IMG_H-1 into layer), and go to FETCH.
REQ-021 SHALL, after last kernel of last pixel of last layer, pulse done=1 for one cycle and return to IDLE.
REQ-022 SHALL drive busy=1 in every state except IDLE; busy=0 in the cycle done=1 is driven.
REQ-023 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle, deassert all request/valid outputs, suppress done; abort has priority over every other input.
REQ-024 SHALL treat start and abort together in IDLE as abort (remain IDLE).
REQ-025 SHALL accept eng_done and wr_ready arriving the same cycle as entry to WAIT/WRITE with zero stall.
REQ-026 SHALL have all outputs registered; per-result cost = 1 RUN + WAIT + WRITE + 1 ADVANCE cycles minimum.
REQ-027 SHALL total NUM_LAYERS*IMG_H*IMG_W*NUM_KERNELS write transfers and NUM_LAYERS*IMG_H*IMG_W patch fetches per frame.

Reset
REQ-028 SHALL on rst_n=0 asynchronously enter IDLE, clear all counters, drive busy, done, patch_req, eng_start, wr_valid to 0 and all address/index outputs to 0.
REQ-029 SHALL, on reset mid-frame, discard frame state; no done on release; next frame needs fresh start.

Verification
REQ-030 SHALL cover: IMG_W=2, IMG_H=2, NUM_LAYERS=2, NUM_KERNELS=3, ack/done/ready tied 1 -> 8 patch fetches, 24 writes in (layer,y,x,kernel) order, one done pulse.
REQ-031 SHALL cover: wr_ready low 5 cycles at first WRITE -> wr_valid held, wr_x=0, wr_y=0, wr_kernel=0 stable, exactly one transfer.
REQ-032 SHALL cover: eng_done pulsed during FETCH and IDLE -> no state change, no spurious write.
REQ-033 SHALL cover: abort in WAIT at layer=1, x=1 -> IDLE next cycle, busy=0, done never asserted, restart begins at layer 0, x=0, y=0.
REQ-034 SHALL cover: rst_n low mid-WRITE -> wr_valid=0 immediately (asynchronous), all outputs 0, start after release runs a full frame.
REQ-035 SHALL cover: start re-pulsed while busy -> ignored; write count still 24 with REQ-030 parameters.
